// File: rtl/seg7_scan_drv_if.sv
// Bundle of the value/strobe inputs and the multiplexed display outputs of seg7_scan_drv.
// master drives the value to show; slave is the display driver.
interface seg7_scan_drv_if;
  logic [7:0] din;
  logic       load;
  logic       mode;
  logic       busy;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output din, load, mode,
    input  busy, seg, dp, an
  );

  modport slave (
    input  din, load, mode,
    output busy, seg, dp, an
  );
endinterface

// File: rtl/seg7_scan_drv.sv
// Shows an 8-bit value on a 4-digit common-anode seven-segment display, either as
// unsigned decimal (sequential double-dabble) or as two hex digits.
module seg7_scan_drv #(
  parameter int SCAN_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  seg7_scan_drv_if.slave   bus
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_reg, state_next;

  logic        busy;
  logic        capture_en;
  logic        shift_en;
  logic        commit_en;

  logic [7:0]  val_reg;
  logic [7:0]  shift_reg;
  logic        mode_reg;
  logic [11:0] bcd_reg;
  logic [2:0]  cnt_reg;
  logic [11:0] bcd_adj;

  logic [3:0]  dig_reg [3];
  logic [2:0]  blank_reg;
  logic        hex_reg;

  logic [PW-1:0] pre_reg;
  logic [1:0]    slot_reg;

  logic [6:0]  seg_reg, seg_next;
  logic        dp_reg, dp_next;
  logic [3:0]  an_reg, an_next;

  logic [6:0]  slot_glyph [4];
  logic        slot_blank [4];
  logic        slot_dp    [4];

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.load) state_next = S_SHIFT;
      S_SHIFT: if (cnt_reg == 3'd7) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    capture_en = 1'b0;
    shift_en   = 1'b0;
    commit_en  = 1'b0;
    case (state_reg)
      S_IDLE:  capture_en = bus.load;
      S_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
      end
      S_DONE: begin
        busy      = 1'b1;
        commit_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Add-3 correction applied to every BCD nibble before each shift.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_reg   <= 8'd0;
      shift_reg <= 8'd0;
      mode_reg  <= 1'b0;
      bcd_reg   <= 12'd0;
      cnt_reg   <= 3'd0;
    end else if (capture_en) begin
      val_reg   <= bus.din;
      shift_reg <= bus.din;
      mode_reg  <= bus.mode;
      bcd_reg   <= 12'd0;
      cnt_reg   <= 3'd0;
    end else if (shift_en) begin
      bcd_reg   <= {bcd_adj[10:0], shift_reg[7]};
      shift_reg <= {shift_reg[6:0], 1'b0};
      cnt_reg   <= cnt_reg + 3'd1;
    end
  end

  // Display registers only change on commit, so the old value stays up during conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_reg[0] <= 4'd0;
      dig_reg[1] <= 4'd0;
      dig_reg[2] <= 4'd0;
      blank_reg  <= 3'b110;
      hex_reg    <= 1'b0;
    end else if (commit_en) begin
      if (mode_reg) begin
        dig_reg[0] <= val_reg[3:0];
        dig_reg[1] <= val_reg[7:4];
        dig_reg[2] <= 4'd0;
        blank_reg  <= 3'b100;
        hex_reg    <= 1'b1;
      end else begin
        dig_reg[0] <= bcd_reg[3:0];
        dig_reg[1] <= bcd_reg[7:4];
        dig_reg[2] <= bcd_reg[11:8];
        blank_reg  <= {bcd_reg[11:8] == 4'd0,
                       (bcd_reg[11:8] == 4'd0) && (bcd_reg[7:4] == 4'd0),
                       1'b0};
        hex_reg    <= 1'b0;
      end
    end
  end

  // ---------------- scan ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_reg  <= '0;
      slot_reg <= 2'd0;
    end else if (pre_reg == PRE_LAST) begin
      pre_reg  <= '0;
      slot_reg <= slot_reg + 2'd1;
    end else begin
      pre_reg  <= pre_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      if (gi < 3) begin : g_digit
        assign slot_glyph[gi] = glyph(dig_reg[gi]);
        assign slot_blank[gi] = blank_reg[gi];
      end else begin : g_spare
        assign slot_glyph[gi] = 7'h7F;
        assign slot_blank[gi] = 1'b1;
      end
      if (gi == 0) begin : g_dp0
        assign slot_dp[gi] = ~hex_reg;
      end else begin : g_dpn
        assign slot_dp[gi] = 1'b1;
      end
    end
  endgenerate

  always_comb begin
    an_next  = 4'hF;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (!slot_blank[slot_reg]) begin
      an_next  = ~(4'b0001 << slot_reg);
      seg_next = slot_glyph[slot_reg];
      dp_next  = slot_dp[slot_reg];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_reg  <= 4'hF;
      seg_reg <= 7'h7F;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign bus.busy = busy;
  assign bus.an   = an_reg;
  assign bus.seg  = seg_reg;
  assign bus.dp   = dp_reg;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Bench for seg7_scan_drv: table vectors, hand-written corner sequences and random
// values, all checked against an arithmetic model of what each display slot should show.
module tb_seg7_scan_drv;

  localparam int SCAN_DIV = 4;
  localparam int SCAN_SAMPLES = 8 * SCAN_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_drv_if bus ();

  seg7_scan_drv #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  lit;    // slots that must light
    logic [27:0] segs;   // expected glyph per slot, slot s at [s*7 +: 7]
    logic [3:0]  dp;     // expected dp per slot (active-low)
  } disp_t;

  typedef struct {
    string      name;
    logic [7:0] din;
    logic       mode;
    logic [3:0] lit;
    logic [6:0] s0, s1, s2;
    logic       dp0;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] gt [16];
  disp_t cur;
  logic [3:0] seen;
  vec_t vecs [7];

  function automatic disp_t from_vec(vec_t v);
    disp_t d;
    d.lit  = v.lit;
    d.segs = {7'h7F, v.s2, v.s1, v.s0};
    d.dp   = {3'b111, v.dp0};
    return d;
  endfunction

  // Reference: decide digits with plain division, then look up glyphs.
  function automatic disp_t model(int v, bit m);
    disp_t d;
    int h, t, o;
    d.lit  = 4'b0000;
    d.segs = '1;
    d.dp   = 4'hF;
    if (m) begin
      d.segs[6:0]  = gt[v % 16];
      d.segs[13:7] = gt[v / 16];
      d.lit        = 4'b0011;
      d.dp[0]      = 1'b0;
    end else begin
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      d.segs[6:0] = gt[o];
      d.lit[0]    = 1'b1;
      if (h != 0 || t != 0) begin
        d.segs[13:7] = gt[t];
        d.lit[1]     = 1'b1;
      end
      if (h != 0) begin
        d.segs[20:14] = gt[h];
        d.lit[2]      = 1'b1;
      end
    end
    return d;
  endfunction

  task automatic check(input bit ok, input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One sample of the display pins against the current expected content.
  task automatic sample(input string tag);
    logic [3:0] a;
    logic [3:0] oh;
    int s;
    a = bus.an;
    s = -1;
    if (a == 4'hF) begin
      check(bus.seg === 7'h7F && bus.dp === 1'b1, {tag, " blank seg/dp"},
            {24'd0, bus.dp, bus.seg}, {24'd0, 1'b1, 7'h7F});
    end else begin
      for (int i = 0; i < 4; i++) begin
        oh = ~(4'b0001 << i);
        if (a == oh) s = i;
      end
      if (s < 0) begin
        check(1'b0, {tag, " an one-hot"}, {28'd0, a}, 32'h0);
      end else begin
        seen[s] = 1'b1;
        check(cur.lit[s] && bus.seg === cur.segs[s*7 +: 7] && bus.dp === cur.dp[s],
              $sformatf("%s slot%0d seg/dp", tag, s),
              {23'd0, cur.lit[s] ? 1'b0 : 1'b1, bus.dp, bus.seg},
              {23'd0, 1'b0, cur.dp[s], cur.segs[s*7 +: 7]});
      end
    end
  endtask

  task automatic scan_check(input string tag);
    seen = 4'b0000;
    for (int i = 0; i < SCAN_SAMPLES; i++) begin
      @(negedge clk);
      sample(tag);
    end
    check(seen == cur.lit, {tag, " lit slots"}, {28'd0, seen}, {28'd0, cur.lit});
  endtask

  // Load a value, verify the old display holds through the conversion, busy length,
  // then the new content. pulse_at >= 0 fires an extra load at that busy cycle.
  task automatic run_txn(input string tag, input logic [7:0] din, input logic mode,
                         input disp_t nxt, input int pulse_at);
    int busy_cnt;
    @(negedge clk);
    bus.din  = din;
    bus.mode = mode;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    busy_cnt = 0;
    while (bus.busy === 1'b1 && busy_cnt < 40) begin
      sample({tag, " hold"});
      busy_cnt++;
      if (busy_cnt == pulse_at) begin
        bus.din  = 8'd9;
        bus.mode = 1'b0;
        bus.load = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
    end
    bus.load = 1'b0;
    check(busy_cnt == 9, {tag, " busy cycles"}, busy_cnt, 9);
    // Display registers commit at the last busy edge; pins follow one cycle later.
    sample({tag, " hold"});
    cur = nxt;
    scan_check(tag);
    $display("txn %-12s din=%3d mode=%0d busy=%0d lit=%b fails=%0d",
             tag, din, mode, busy_cnt, seen, n_fail);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    disp_t d;
    int v;
    bit m;
    gt = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    vecs[0] = '{"dec255", 8'd255, 1'b0, 4'b0111, 7'b0010010, 7'b0010010, 7'b0100100, 1'b1};
    vecs[1] = '{"dec7",   8'd7,   1'b0, 4'b0001, 7'b1111000, 7'h7F,      7'h7F,      1'b1};
    vecs[2] = '{"dec40",  8'd40,  1'b0, 4'b0011, 7'b1000000, 7'b0011001, 7'h7F,      1'b1};
    vecs[3] = '{"hexA5",  8'hA5,  1'b1, 4'b0011, 7'b0010010, 7'b0001000, 7'h7F,      1'b0};
    vecs[4] = '{"dec100", 8'd100, 1'b0, 4'b0111, 7'b1000000, 7'b1000000, 7'b1111001, 1'b1};
    vecs[5] = '{"hex3C",  8'h3C,  1'b1, 4'b0011, 7'b1000110, 7'b0110000, 7'h7F,      1'b0};
    vecs[6] = '{"dec0",   8'd0,   1'b0, 4'b0001, 7'b1000000, 7'h7F,      7'h7F,      1'b1};

    bus.din  = 8'd0;
    bus.mode = 1'b0;
    bus.load = 1'b0;

    // Reset state, then the power-on single '0'.
    @(negedge clk);
    check(bus.an === 4'hF && bus.seg === 7'h7F && bus.dp === 1'b1 && bus.busy === 1'b0,
          "reset outputs", {19'd0, bus.busy, bus.an, bus.dp, bus.seg}, {19'd0, 1'b0, 4'hF, 1'b1, 7'h7F});
    @(negedge clk);
    rst = 1'b0;
    cur = from_vec(vecs[6]);
    scan_check("post_reset");
    $display("txn %-12s lit=%b fails=%0d", "post_reset", seen, n_fail);

    foreach (vecs[i]) run_txn(vecs[i].name, vecs[i].din, vecs[i].mode, from_vec(vecs[i]), -1);

    // Busy lockout: second load at busy cycle 3 is dropped.
    run_txn("lockout", 8'd100, 1'b0, from_vec(vecs[4]), 3);
    run_txn("dec7_again", 8'd7, 1'b0, from_vec(vecs[1]), -1);

    // Asynchronous reset during SHIFT cycle 4 aborts the pending value.
    @(negedge clk);
    bus.din  = 8'd200;
    bus.mode = 1'b0;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    check(bus.busy === 1'b1, "midrst busy before", {31'd0, bus.busy}, 1);
    #2 rst = 1'b1;
    #1;
    check(bus.busy === 1'b0 && bus.an === 4'hF && bus.seg === 7'h7F && bus.dp === 1'b1,
          "midrst async outputs", {19'd0, bus.busy, bus.an, bus.dp, bus.seg},
          {19'd0, 1'b0, 4'hF, 1'b1, 7'h7F});
    @(negedge clk);
    rst = 1'b0;
    cur = from_vec(vecs[6]);
    scan_check("midrst");
    $display("txn %-12s lit=%b fails=%0d", "midrst", seen, n_fail);

    // Random values against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      v = int'($urandom_range(255));
      m = bit'($urandom_range(1));
      d = model(v, m);
      run_txn($sformatf("rand%0d", i), 8'(v), m, d, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
